// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead add/subtract unit with a valid/ready stream interface.
// Optional build macro: ADDER_SATURATE_EN clamps the final sum to the signed extreme on overflow.
module pipelined_cla_adder #(
  parameter int WIDTH  = 32,
  parameter int BLOCK  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int SEG_W    = WIDTH / STAGES;
  localparam int N_GROUPS = SEG_W / BLOCK;
  localparam int LAST     = STAGES - 1;

  generate
    if (STAGES < 1 || STAGES > 4 || (WIDTH % (STAGES * BLOCK)) != 0) begin : g_param_check
      $error("pipelined_cla_adder: STAGES must be 1..4 and WIDTH a multiple of STAGES*BLOCK");
    end
  endgenerate

  // One segment: BLOCK-bit lookahead groups, each group's carry-out formed from its own
  // generate/propagate terms plus the group carry-in.
  function automatic logic [SEG_W:0] cla_seg(input logic [SEG_W-1:0] x,
                                             input logic [SEG_W-1:0] y,
                                             input logic             c_in);
    logic [SEG_W-1:0] g;
    logic [SEG_W-1:0] p;
    logic [SEG_W:0]   c;
    logic             grp_g;
    logic             grp_p;
    g    = x & y;
    p    = x ^ y;
    c    = '0;
    c[0] = c_in;
    for (int grp = 0; grp < N_GROUPS; grp++) begin
      for (int i = 1; i <= BLOCK; i++) begin
        grp_g = 1'b0;
        grp_p = 1'b1;
        for (int k = i - 1; k >= 0; k--) begin
          grp_g = grp_g | (grp_p & g[grp*BLOCK + k]);
          grp_p = grp_p & p[grp*BLOCK + k];
        end
        c[grp*BLOCK + i] = grp_g | (grp_p & c[grp*BLOCK]);
      end
    end
    return {c[SEG_W], p ^ c[SEG_W-1:0]};
  endfunction

  logic             r_v   [STAGES];
  logic [WIDTH-1:0] r_a   [STAGES];
  logic [WIDTH-1:0] r_b   [STAGES];
  logic [WIDTH-1:0] r_s   [STAGES];
  logic             r_c   [STAGES];
  logic             r_ovf;

  logic             w_v   [STAGES];
  logic [WIDTH-1:0] w_a   [STAGES];
  logic [WIDTH-1:0] w_b   [STAGES];
  logic [WIDTH-1:0] w_s   [STAGES];
  logic             w_c   [STAGES];
  logic [STAGES:0]  w_ready;
  logic [WIDTH-1:0] w_b_eff;
  logic [SEG_W:0]   w_seg;
  logic             w_ovf;

  // NOTE: every variable written here gets a value on every path before any branch;
  // a path that skips an assignment would infer a latch.
  always_comb begin
    w_ready         = '0;
    w_ready[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      w_ready[k] = !r_v[k] || w_ready[k+1];
    end

    w_b_eff = sub ? ~b : b;

    // Stage 0 resolves the low segment straight from the ports; subtract forces carry-in to 1.
    w_seg                = cla_seg(a[SEG_W-1:0], w_b_eff[SEG_W-1:0], sub | cin);
    w_v[0]               = in_valid;
    w_a[0]               = a;
    w_b[0]               = w_b_eff;
    w_s[0]               = '0;
    w_s[0][SEG_W-1:0]    = w_seg[SEG_W-1:0];
    w_c[0]               = w_seg[SEG_W];

    for (int k = 1; k < STAGES; k++) begin
      w_seg                    = cla_seg(r_a[k-1][k*SEG_W +: SEG_W], r_b[k-1][k*SEG_W +: SEG_W], r_c[k-1]);
      w_v[k]                   = r_v[k-1];
      w_a[k]                   = r_a[k-1];
      w_b[k]                   = r_b[k-1];
      w_s[k]                   = r_s[k-1];
      w_s[k][k*SEG_W +: SEG_W] = w_seg[SEG_W-1:0];
      w_c[k]                   = w_seg[SEG_W];
    end

    w_ovf = (w_a[LAST][WIDTH-1] == w_b[LAST][WIDTH-1]) &&
            (w_s[LAST][WIDTH-1] != w_a[LAST][WIDTH-1]);

`ifdef ADDER_SATURATE_EN
    // Both operands share a sign on overflow, so the operand sign picks the clamp direction.
    if (w_ovf) begin
      w_s[LAST] = w_a[LAST][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  // NOTE: state updates use non-blocking assignments so every stage samples the
  // pre-edge value of its predecessor; blocking here would shoot beats through stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the data registers are reset too, not just the valids, because the
      // last stage drives sum/cout/overflow directly and must read zero after reset.
      for (int k = 0; k < STAGES; k++) begin
        r_v[k] <= 1'b0;
        r_a[k] <= '0;
        r_b[k] <= '0;
        r_s[k] <= '0;
        r_c[k] <= 1'b0;
      end
      r_ovf <= 1'b0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (w_ready[k]) begin
          r_v[k] <= w_v[k];
          if (w_v[k]) begin
            r_a[k] <= w_a[k];
            r_b[k] <= w_b[k];
            r_s[k] <= w_s[k];
            r_c[k] <= w_c[k];
          end
        end
      end
      if (w_ready[LAST] && w_v[LAST]) begin
        r_ovf <= w_ovf;
      end
    end
  end

  // Gating with rst keeps a downstream consumer from taking a beat that reset is discarding.
  assign in_ready  = !rst && w_ready[0];
  assign out_valid = !rst && r_v[LAST];
  assign sum       = r_s[LAST];
  assign cout      = r_c[LAST];
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Directed self-checking bench for pipelined_cla_adder (32/4/2), plus 16/1 and 64/4 instances
// compared against a behavioural +/- reference.
module tb_pipelined_cla_adder;

  localparam int STAGES = 2;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, sum;
  logic        cin, sub, cout, overflow;

  logic        sw_valid;
  logic        one = 1'b1;
  logic [15:0] s16_a, s16_b, s16_sum;
  logic        s16_cin, s16_sub, s16_in_ready, s16_out_valid, s16_cout, s16_ovf;
  logic [63:0] s64_a, s64_b, s64_sum;
  logic        s64_cin, s64_sub, s64_in_ready, s64_out_valid, s64_cout, s64_ovf;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  bit          lat_chk = 1'b0;
  bit          held = 1'b0;
  logic [31:0] held_sum;
  exp_t        exp_q[$];
  logic [71:0] q16[$];
  logic [71:0] q64[$];
  vec_t        dir_v[3];
  vec_t        strm_v[8];
  vec_t        bp_v[6];
  vec_t        rs_v[3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pipelined_cla_adder #(.WIDTH(32), .BLOCK(4), .STAGES(STAGES)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .cout(cout), .overflow(overflow)
  );

  pipelined_cla_adder #(.WIDTH(16), .BLOCK(4), .STAGES(1)) dut16 (
    .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(s16_in_ready), .a(s16_a), .b(s16_b),
    .cin(s16_cin), .sub(s16_sub), .out_valid(s16_out_valid), .out_ready(one), .sum(s16_sum),
    .cout(s16_cout), .overflow(s16_ovf)
  );

  pipelined_cla_adder #(.WIDTH(64), .BLOCK(4), .STAGES(4)) dut64 (
    .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(s64_in_ready), .a(s64_a), .b(s64_b),
    .cin(s64_cin), .sub(s64_sub), .out_valid(s64_out_valid), .out_ready(one), .sum(s64_sum),
    .cout(s64_cout), .overflow(s64_ovf)
  );

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] va, input logic [31:0] vb, input logic vcin,
                              input logic vsub, input logic [31:0] vsum, input logic vcout,
                              input logic vovf);
    return '{a: va, b: vb, cin: vcin, sub: vsub, sum: vsum, cout: vcout, ovf: vovf};
  endfunction

  function automatic logic [31:0] exp_sum(input vec_t v);
`ifdef ADDER_SATURATE_EN
    if (v.ovf) return v.a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
    return v.sum;
  endfunction

  // Behavioural reference for the sweep instances: {6'b0, ovf, cout, sum zero-extended to 64}.
  function automatic logic [71:0] ref_add(input int w, input logic [63:0] x, input logic [63:0] y,
                                          input logic ci, input logic sb);
    logic [63:0] mask, xe, ye, s;
    logic [64:0] t;
    logic        c, o;
    mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    xe   = x & mask;
    ye   = (sb ? ~y : y) & mask;
    t    = {1'b0, xe} + {1'b0, ye} + {64'd0, (sb | ci)};
    s    = t[63:0] & mask;
    c    = t[w];
    o    = (xe[w-1] == ye[w-1]) && (s[w-1] != xe[w-1]);
`ifdef ADDER_SATURATE_EN
    if (o) s = xe[w-1] ? (64'd1 << (w - 1)) : ((64'd1 << (w - 1)) - 64'd1);
`endif
    return {6'b0, o, c, s};
  endfunction

  // Entered and left at posedge+1; holds the beat until accepted.
  task automatic send(input vec_t v);
    a        = v.a;
    b        = v.b;
    cin      = v.cin;
    sub      = v.sub;
    in_valid = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back('{sum: exp_sum(v), cout: v.cout, ovf: v.ovf, acc: cyc});
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    check("send_timeout", 72'd0, 72'd1);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    for (int t = 0; t < 60 && exp_q.size() != 0; t++) @(posedge clk);
    #1;
    check(tag, exp_q.size(), 0);
  endtask

  // Output monitor: order, values, latency, stability under stall.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      exp_q.delete();
      held = 1'b0;
    end else begin
      if (out_valid && !out_ready) begin
        if (held) check("stall_stable", sum, held_sum);
        held     = 1'b1;
        held_sum = sum;
      end else begin
        held = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", 72'd1, 72'd0);
        end else begin
          e = exp_q.pop_front();
          check("sum", sum, e.sum);
          check("cout", cout, e.cout);
          check("ovf", overflow, e.ovf);
          if (lat_chk) check("latency", cyc - e.acc, STAGES);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && s16_out_valid) begin
      if (q16.size() == 0) check("sw16_spurious", 72'd1, 72'd0);
      else check("sw16", {6'b0, s16_ovf, s16_cout, 48'd0, s16_sum}, q16.pop_front());
    end
    if (!rst && s64_out_valid) begin
      if (q64.size() == 0) check("sw64_spurious", 72'd1, 72'd0);
      else check("sw64", {6'b0, s64_ovf, s64_cout, s64_sum}, q64.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    dir_v[0]  = mk(32'h7FFF_FFFF, 32'h0000_0001, 0, 0, 32'h8000_0000, 0, 1);
    dir_v[1]  = mk(32'd100,       32'd50,        0, 1, 32'd50,        1, 0);
    dir_v[2]  = mk(32'h8000_0000, 32'h0000_0001, 0, 1, 32'h7FFF_FFFF, 1, 1);

    strm_v[0] = mk(32'd200,       32'd150,       0, 0, 32'd350,       0, 0);
    strm_v[1] = mk(-32'sd100,     -32'sd200,     0, 0, 32'hFFFF_FED4, 1, 0);
    strm_v[2] = mk(32'd50,        32'd75,        0, 0, 32'd125,       0, 0);
    strm_v[3] = mk(-32'sd50,      32'd50,        0, 0, 32'd0,         1, 0);
    strm_v[4] = mk(32'h0000_FFFF, 32'h0000_0001, 0, 0, 32'h0001_0000, 0, 0);
    strm_v[5] = mk(32'hFFFF_FFFF, 32'h0000_0000, 1, 0, 32'd0,         1, 0);
    strm_v[6] = mk(32'd10,        32'd3,         1, 1, 32'd7,         1, 0);
    strm_v[7] = mk(32'd0,         32'd1,         0, 1, 32'hFFFF_FFFF, 0, 0);

    bp_v[0]   = mk(32'h8000_0000, 32'h8000_0000, 0, 0, 32'd0,         1, 1);
    bp_v[1]   = mk(32'd1,         32'd2,         1, 0, 32'd4,         0, 0);
    bp_v[2]   = mk(32'h1234_5678, 32'h8765_4321, 0, 0, 32'h9999_9999, 0, 0);
    bp_v[3]   = mk(32'h7FFF_FFFF, 32'hFFFF_FFFF, 0, 1, 32'h8000_0000, 0, 1);
    bp_v[4]   = mk(32'd5,         32'd5,         0, 1, 32'd0,         1, 0);
    bp_v[5]   = mk(32'hFFFF_0000, 32'h0001_0000, 0, 0, 32'd0,         1, 0);

    rs_v[0]   = mk(32'd1,         32'd1,         0, 0, 32'd2,         0, 0);
    rs_v[1]   = mk(32'd3,         32'd3,         0, 0, 32'd6,         0, 0);
    rs_v[2]   = mk(32'd9,         32'd9,         0, 0, 32'd18,        0, 0);

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    sw_valid = 1'b0; s16_a = '0; s16_b = '0; s16_cin = 1'b0; s16_sub = 1'b0;
    s64_a = '0; s64_b = '0; s64_cin = 1'b0; s64_sub = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_out_valid", out_valid, 0);
    check("post_rst_sum", sum, 0);
    check("post_rst_cout_ovf", {cout, overflow}, 0);

    // Overflow and subtract, isolated beats with latency checked
    lat_chk = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send(dir_v[i]);
      wait_drain("dir_drain");
    end

    // Back-to-back stream: latency check also proves consecutive outputs
    for (int i = 0; i < 8; i++) send(strm_v[i]);
    wait_drain("stream_drain");
    lat_chk = 1'b0;

    // Fill with the output stalled, then drain and accept in the same cycle
    out_ready = 1'b0;
    send(bp_v[0]);
    send(bp_v[1]);
    a = bp_v[2].a; b = bp_v[2].b; cin = bp_v[2].cin; sub = bp_v[2].sub; in_valid = 1'b1;
    @(negedge clk);
    check("full_in_ready", in_ready, 0);
    check("full_out_valid", out_valid, 1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    #1;
    check("drain_in_ready", in_ready, 1);
    check("drain_out_valid", out_valid, 1);
    send(bp_v[2]);
    wait_drain("full_drain");

    // Toggling backpressure
    fork
      begin
        for (int i = 0; i < 6; i++) send(bp_v[i]);
      end
      begin
        for (int t = 0; t < 30; t++) begin
          out_ready = (t % 3 == 0);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    wait_drain("bp_drain");

    // Reset with two beats in flight
    send(rs_v[0]);
    send(rs_v[1]);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("after_rst_out_valid", out_valid, 0);
    check("after_rst_sum", sum, 0);
    check("after_rst_in_ready", in_ready, 1);
    lat_chk = 1'b1;
    send(rs_v[2]);
    wait_drain("rst_drain");
    lat_chk = 1'b0;

    // Parameter sweep against the behavioural reference
    for (int i = 0; i < 1000; i++) begin
      if (i % 100 == 0) begin
        s16_a = 16'h7FFF; s16_b = 16'h0001; s16_cin = 1'b0; s16_sub = 1'b0;
        s64_a = 64'h8000_0000_0000_0000; s64_b = 64'd1; s64_cin = 1'b0; s64_sub = 1'b1;
      end else begin
        s16_a   = 16'($urandom);
        s16_b   = 16'($urandom);
        s16_cin = 1'($urandom_range(0, 1));
        s16_sub = 1'($urandom_range(0, 1));
        s64_a   = {$urandom, $urandom};
        s64_b   = {$urandom, $urandom};
        s64_cin = 1'($urandom_range(0, 1));
        s64_sub = 1'($urandom_range(0, 1));
      end
      sw_valid = 1'b1;
      @(negedge clk);
      if (s16_in_ready) q16.push_back(ref_add(16, {48'd0, s16_a}, {48'd0, s16_b}, s16_cin, s16_sub));
      else check("sw16_in_ready", 72'd0, 72'd1);
      if (s64_in_ready) q64.push_back(ref_add(64, s64_a, s64_b, s64_cin, s64_sub));
      else check("sw64_in_ready", 72'd0, 72'd1);
      @(posedge clk); #1;
    end
    sw_valid = 1'b0;
    for (int t = 0; t < 20 && (q16.size() != 0 || q64.size() != 0); t++) @(posedge clk);
    #1;
    check("sweep_drain", q16.size() + q64.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
